// File: rtl/serial_chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_chunk_adder : chunk-serial add/subtract, LSB chunk first     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module serial_chunk_adder #(
  parameter int DATA_WIDTH  = 8,
  parameter int CHUNK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int C_CNT_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_CHUNK = C_CNT_W'(NUM_CHUNKS - 1);

  generate
    if (CHUNK_WIDTH < 1 || (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk_width
      $error("serial_chunk_adder: CHUNK_WIDTH must divide DATA_WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_carry;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_a_msb;
  logic                  r_b_msb;

  logic [CHUNK_WIDTH:0]  w_chunk;
  logic [DATA_WIDTH-1:0] w_top;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [DATA_WIDTH-1:0] w_b_eff;

  // Operands shift right so the active chunk is always the low slice; the
  // accumulator fills from the top, leaving the result aligned after the last chunk.
  assign w_chunk    = {1'b0, r_a[CHUNK_WIDTH-1:0]} + {1'b0, r_b[CHUNK_WIDTH-1:0]}
                    + {{CHUNK_WIDTH{1'b0}}, r_carry};
  assign w_top      = DATA_WIDTH'(w_chunk[CHUNK_WIDTH-1:0]) << (DATA_WIDTH - CHUNK_WIDTH);
  assign w_acc_next = (r_acc >> CHUNK_WIDTH) | w_top;
  assign w_b_eff    = sub ? ~b : b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_a_msb <= a[DATA_WIDTH-1];
            r_b_msb <= w_b_eff[DATA_WIDTH-1];
            r_carry <= sub ? 1'b1 : carry_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CHUNK_WIDTH;
          r_b     <= r_b >> CHUNK_WIDTH;
          r_acc   <= w_acc_next;
          r_carry <= w_chunk[CHUNK_WIDTH];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST_CHUNK) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            sum       <= w_acc_next;
            carry_out <= w_chunk[CHUNK_WIDTH];
            overflow  <= (r_a_msb == r_b_msb) && (w_acc_next[DATA_WIDTH-1] != r_a_msb);
            r_state   <= S_FIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
